// File: rtl/groestl_pkg.sv
// Shared constants and state encoding for the Groestl message loader.
package groestl_pkg;
    localparam int WORD_W          = 16;
    localparam int MSG_W           = 512;
    localparam int WORDS_PER_BLOCK = 32;
    localparam int CNT_W           = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        READY = 2'b10,
        START = 2'b11
    } state_t;
endpackage

// File: rtl/groestl_msg_loader.sv
// Collects 32 16-bit words into one 512-bit block, MSW first, and hands it
// to the hash core with a one-cycle start pulse once the core is idle.
module groestl_msg_loader
    import groestl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                wr_en,
    input  logic [WORD_W-1:0]   idata,
    input  logic                busy,
    output logic                ack,
    output logic                full,
    output logic                start,
    output logic [CNT_W-1:0]    word_cnt,
    output logic [MSG_W-1:0]    msg
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [MSG_W-1:0]   msg_q, msg_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
            msg_q      <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            msg_q      <= msg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        msg_d      = msg_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d    = FILL;
                    word_cnt_d = '0;
                end
            end
            FILL: begin
                if (wr_en) begin
                    msg_d[MSG_W-1-WORD_W*int'(word_cnt_q) -: WORD_W] = idata;
                    // Counter wraps to 0 naturally on the 32nd word.
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    if (word_cnt_q == CNT_W'(WORDS_PER_BLOCK-1))
                        state_d = READY;
                end
            end
            READY: begin
                if (!busy)
                    state_d = START;
            end
            START: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ack      = (state_q == FILL);
    assign full     = (state_q == READY) || (state_q == START);
    assign start    = (state_q == START);
    assign word_cnt = word_cnt_q;
    assign msg      = msg_q;

endmodule

// File: tb/tb_groestl_msg_loader.sv
// Randomized self-checking bench for groestl_msg_loader.
module tb_groestl_msg_loader;

    logic         clk = 1'b0;
    logic         rst, load, wr_en, busy;
    logic [15:0]  idata;
    logic         ack, full, start;
    logic [4:0]   word_cnt;
    logic [511:0] msg;

    int           n_checks = 0;
    int           n_fail   = 0;
    logic [15:0]  blk [32];
    logic [511:0] exp_msg;

    groestl_msg_loader dut (
        .clk(clk), .rst(rst), .load(load), .wr_en(wr_en), .idata(idata),
        .busy(busy), .ack(ack), .full(full), .start(start),
        .word_cnt(word_cnt), .msg(msg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference block: first word ends up in the top 16 bits.
    function automatic logic [511:0] pack_blk();
        logic [511:0] r = '0;
        for (int i = 0; i < 32; i++) r = {r[495:0], blk[i]};
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; wr_en = 1'b0; busy = 1'b0; idata = '0;
        #3;
        n_checks++;
        if ({ack, full, start, word_cnt, msg} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: actual ack=%b full=%b start=%b cnt=%0d msg_nz=%b required all zero",
                     ack, full, start, word_cnt, |msg);
        end
        cyc(); cyc();
        rst = 1'b0;
        // Writes while idle must be ignored and nothing may move without load.
        wr_en = 1'b1; idata = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_checks++;
            if ({ack, full, start, word_cnt} !== 8'd0 || msg !== '0) begin
                n_fail++;
                $display("FAIL idle_ignore: actual ack=%b full=%b start=%b cnt=%0d msg_nz=%b required idle zeros",
                         ack, full, start, word_cnt, |msg);
            end
        end
        wr_en = 1'b0;
        exp_msg = '0;
    endtask

    task automatic test_back_to_back(input bit rnd);
        int starts = 0;
        for (int i = 0; i < 32; i++) blk[i] = rnd ? 16'($urandom) : 16'(i);
        load = 1'b1;
        cyc();
        load = 1'b0;
        n_checks++;
        if ({ack, full, start, word_cnt} !== {3'b100, 5'd0}) begin
            n_fail++;
            $display("FAIL b2b_load_ack: actual ack=%b full=%b start=%b cnt=%0d required ack=1 cnt=0",
                     ack, full, start, word_cnt);
        end
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; idata = blk[i];
            cyc();
            n_checks++;
            if (i < 31) begin
                if (ack !== 1'b1 || word_cnt !== 5'(i + 1)) begin
                    n_fail++;
                    $display("FAIL b2b_count: actual ack=%b cnt=%0d required ack=1 cnt=%0d", ack, word_cnt, i + 1);
                end
            end else if ({ack, full, start, word_cnt} !== {3'b010, 5'd0}) begin
                n_fail++;
                $display("FAIL b2b_ready: actual ack=%b full=%b start=%b cnt=%0d required full=1 cnt=0",
                         ack, full, start, word_cnt);
            end
        end
        wr_en = 1'b0;
        exp_msg = pack_blk();
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (start === 1'b1) starts++;
            if (k == 0) begin
                n_checks++;
                if (start !== 1'b1 || full !== 1'b1 || msg !== exp_msg) begin
                    n_fail++;
                    $display("FAIL b2b_start: actual start=%b full=%b msg=%h required start=1 full=1 msg=%h",
                             start, full, msg, exp_msg);
                end
            end
        end
        n_checks++;
        if (starts != 1 || {ack, full, start} !== 3'b000 || msg !== exp_msg) begin
            n_fail++;
            $display("FAIL b2b_after: actual starts=%0d ack=%b full=%b msg=%h required starts=1 idle msg=%h",
                     starts, ack, full, msg, exp_msg);
        end
    endtask

    task automatic test_stall();
        int got = 0;
        int cnt_exp = 0;
        for (int i = 0; i < 32; i++) blk[i] = 16'($urandom);
        load = 1'b1;
        cyc();
        load = 1'b0;
        for (int c = 0; got < 32 && c < 200; c++) begin
            wr_en = c[0];
            idata = wr_en ? blk[got] : 16'($urandom);
            cyc();
            if (wr_en) begin
                got++;
                cnt_exp = got % 32;
            end
            if (got < 32) begin
                n_checks++;
                if (ack !== 1'b1 || word_cnt !== 5'(cnt_exp)) begin
                    n_fail++;
                    $display("FAIL stall_fill: actual ack=%b cnt=%0d required ack=1 cnt=%0d", ack, word_cnt, cnt_exp);
                end
            end
        end
        wr_en = 1'b0;
        exp_msg = pack_blk();
        cyc();
        n_checks++;
        if (start !== 1'b1 || msg !== exp_msg) begin
            n_fail++;
            $display("FAIL stall_msg: actual start=%b msg=%h required start=1 msg=%h", start, msg, exp_msg);
        end
        cyc();
    endtask

    task automatic test_busy();
        for (int i = 0; i < 32; i++) blk[i] = 16'($urandom);
        busy = 1'b1;
        load = 1'b1;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; idata = blk[i];
            cyc();
        end
        wr_en = 1'b0;
        exp_msg = pack_blk();
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (full !== 1'b1 || start !== 1'b0 || msg !== exp_msg) begin
                n_fail++;
                $display("FAIL busy_hold[%0d]: actual full=%b start=%b required full=1 start=0 msg stable",
                         k, full, start);
            end
            if (k < 9) cyc();
        end
        busy = 1'b0;
        cyc();
        n_checks++;
        if (start !== 1'b1 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_release: actual start=%b full=%b required start=1 full=1", start, full);
        end
        cyc();
        n_checks++;
        if (start !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_single: actual start=%b full=%b required start=0 full=0", start, full);
        end
    endtask

    task automatic test_load_ignored();
        int starts = 0;
        for (int i = 0; i < 32; i++) blk[i] = 16'($urandom);
        load = 1'b1;
        cyc();
        for (int i = 0; i < 32; i++) begin
            load  = (i == 7);
            wr_en = 1'b1; idata = blk[i];
            cyc();
            if (i == 7 || i == 8) begin
                n_checks++;
                if (word_cnt !== 5'(i + 1) || ack !== 1'b1) begin
                    n_fail++;
                    $display("FAIL load_in_fill: actual cnt=%0d ack=%b required cnt=%0d ack=1", word_cnt, ack, i + 1);
                end
            end
        end
        exp_msg = pack_blk();
        // READY now: load and a stray write both must be ignored.
        load = 1'b1; wr_en = 1'b1; idata = 16'hFFFF;
        cyc();
        load = 1'b0;
        if (start === 1'b1) starts++;
        n_checks++;
        if (start !== 1'b1 || msg !== exp_msg) begin
            n_fail++;
            $display("FAIL load_in_ready: actual start=%b msg=%h required start=1 msg=%h", start, msg, exp_msg);
        end
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (start === 1'b1) starts++;
            wr_en = 1'b1; idata = 16'hFFFF;
        end
        wr_en = 1'b0;
        n_checks++;
        if (starts != 1 || ack !== 1'b0 || word_cnt !== 5'd0 || msg !== exp_msg) begin
            n_fail++;
            $display("FAIL load_ignored_end: actual starts=%0d ack=%b cnt=%0d required starts=1 ack=0 cnt=0 msg stable",
                     starts, ack, word_cnt);
        end
    endtask

    task automatic test_reset_mid();
        load = 1'b1;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; idata = 16'($urandom);
            cyc();
        end
        wr_en = 1'b0;
        n_checks++;
        if (word_cnt !== 5'd20) begin
            n_fail++;
            $display("FAIL reset_mid_pre: actual cnt=%0d required cnt=20", word_cnt);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ack, full, start, word_cnt} !== 8'd0 || msg !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_fill: actual ack=%b cnt=%0d msg_nz=%b required all zero", ack, word_cnt, |msg);
        end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) blk[i] = 16'hA5A5;
        load = 1'b1;
        cyc();
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; idata = blk[i];
            cyc();
        end
        wr_en = 1'b0;
        cyc();
        n_checks++;
        if (start !== 1'b1 || msg !== {32{16'hA5A5}}) begin
            n_fail++;
            $display("FAIL reset_refill: actual start=%b msg=%h required start=1 all A5A5", start, msg);
        end
        // Reset landing in the START cycle must kill the pulse at once.
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ack, full, start, word_cnt} !== 8'd0 || msg !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_start: actual start=%b full=%b msg_nz=%b required all zero", start, full, |msg);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_stall();
        test_busy();
        test_load_ignored();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
